// File: rtl/tjpu_layer_sequencer.sv
// tjpu_layer_sequencer
// Layer-level scheduler in front of the TJPU compute top. Pops one layer descriptor at a
// time, programs the switch routing and the Reg_4..Reg_9 parameter words, pulses a one-cycle
// start code to the conv 3x3 or reshape/concat engine, then waits for the layer's last output
// beat and the engine going idle before fetching the next descriptor. A watchdog covers the
// RUN/DRAIN wait and raises a sticky error toward the PS.
module tjpu_layer_sequencer #(
    parameter logic [3:0]  CTRL_START = 4'b0001,
    parameter int unsigned TIMEOUT_W  = 24,
    parameter int unsigned LAYER_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               desc_valid,
    output logic               desc_ready,
    input  logic [1:0]         desc_op,
    input  logic [191:0]       desc_regs,
    output logic [31:0]        Switch,
    output logic [31:0]        Reg_4,
    output logic [31:0]        Reg_5,
    output logic [31:0]        Reg_6,
    output logic [31:0]        Reg_7,
    output logic [31:0]        Reg_8,
    output logic [31:0]        Reg_9,
    output logic [3:0]         Control_3_3,
    output logic [7:0]         Control_RE,
    input  logic [3:0]         State_3_3,
    input  logic [7:0]         State_RE,
    input  logic               M_Last,
    output logic               busy,
    output logic [LAYER_W-1:0] layer_cnt,
    output logic               irq_done,
    output logic               irq_err
);

    typedef enum logic [2:0] {
        StIdle,
        StConfig,
        StStart,
        StRun,
        StDrain,
        StErr
    } state_e;

    typedef enum logic [1:0] {
        OpConv    = 2'd0,
        OpReshape = 2'd1,
        OpConcat  = 2'd2,
        OpEnd     = 2'd3
    } op_e;

    // Switch words: {24'b0, suppress[3:0], 2'b0, dest[1:0]}
    localparam logic [31:0] SwitchConv = {24'd0, 4'b1110, 2'b00, 2'd0};
    localparam logic [31:0] SwitchRe   = {24'd0, 4'b0111, 2'b00, 2'd3};

    state_e               state_q, state_d;
    op_e                  op_q, op_d;
    op_e                  desc_op_e;
    logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
    logic [191:0]         regs_q, regs_d;
    logic [31:0]          switch_q, switch_d;
    logic [3:0]           ctrl33_q, ctrl33_d;
    logic [7:0]           ctrlre_q, ctrlre_d;
    logic [LAYER_W-1:0]   layer_cnt_q, layer_cnt_d;
    logic                 desc_ready_q, desc_ready_d;
    logic                 busy_q, busy_d;
    logic                 irq_done_q, irq_done_d;
    logic                 irq_err_q, irq_err_d;

    logic accept;
    logic accept_layer;
    logic accept_end;
    logic in_watch;
    logic timeout;
    logic engine_idle;
    logic layer_done;

    assign desc_op_e    = op_e'(desc_op);
    // desc_ready_q is only ever high in IDLE, so the state term is belt and braces.
    assign accept       = (state_q == StIdle) && desc_valid && desc_ready_q;
    assign accept_layer = accept && (desc_op_e != OpEnd);
    assign accept_end   = accept && (desc_op_e == OpEnd);

    assign in_watch = (state_q == StRun) || (state_q == StDrain);
    assign wd_inc   = wd_q + TIMEOUT_W'(1);
    // Timeout after 2^TIMEOUT_W-1 cycles spent in RUN/DRAIN; it outranks any progress.
    assign timeout  = in_watch && (wd_inc == '1);

    assign engine_idle = (op_q == OpConv) ? (State_3_3 == 4'd0) : (State_RE == 8'd0);
    assign layer_done  = (state_q == StDrain) && !timeout && engine_idle;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; M_Last is only looked at in RUN, so stray beats elsewhere are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept_layer) begin
                    state_d = StConfig;
                end
            end
            StConfig: state_d = StStart;
            StStart:  state_d = StRun;
            StRun: begin
                if (timeout) begin
                    state_d = StErr;
                end else if (M_Last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (timeout) begin
                    state_d = StErr;
                end else if (engine_idle) begin
                    state_d = StIdle;
                end
            end
            StErr:   state_d = StErr;
            default: state_d = StIdle;
        endcase
    end

    // Output next values; every output is registered from these.
    always_comb begin
        op_d        = op_q;
        regs_d      = regs_q;
        switch_d    = switch_q;
        ctrl33_d    = '0;
        ctrlre_d    = '0;
        layer_cnt_d = layer_cnt_q;
        wd_d        = wd_q;

        // Parameter words and routing only move on a layer descriptor accept.
        if (accept_layer) begin
            op_d     = desc_op_e;
            regs_d   = desc_regs;
            switch_d = (desc_op_e == OpConv) ? SwitchConv : SwitchRe;
        end

        // Start code is registered from next state so it is visible exactly in START.
        if ((state_d == StStart) && !irq_err_q) begin
            unique case (op_q)
                OpConv:    ctrl33_d        = CTRL_START;
                OpReshape: ctrlre_d[3:0]   = CTRL_START;
                OpConcat:  ctrlre_d[7:4]   = CTRL_START;
                default:   ;
            endcase
        end

        if (accept_end) begin
            layer_cnt_d = '0;
        end else if (layer_done) begin
            layer_cnt_d = layer_cnt_q + LAYER_W'(1);
        end

        // START always hands over to RUN, so clearing here clears on RUN entry.
        if (state_q == StStart) begin
            wd_d = '0;
        end else if (in_watch) begin
            wd_d = wd_inc;
        end

        irq_done_d   = accept_end;
        irq_err_d    = irq_err_q || timeout;
        busy_d       = (state_d != StIdle);
        desc_ready_d = (state_d == StIdle) && run && !irq_err_d;
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q         <= OpConv;
            regs_q       <= '0;
            switch_q     <= '0;
            ctrl33_q     <= '0;
            ctrlre_q     <= '0;
            layer_cnt_q  <= '0;
            wd_q         <= '0;
            irq_done_q   <= 1'b0;
            irq_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            desc_ready_q <= 1'b0;
        end else begin
            op_q         <= op_d;
            regs_q       <= regs_d;
            switch_q     <= switch_d;
            ctrl33_q     <= ctrl33_d;
            ctrlre_q     <= ctrlre_d;
            layer_cnt_q  <= layer_cnt_d;
            wd_q         <= wd_d;
            irq_done_q   <= irq_done_d;
            irq_err_q    <= irq_err_d;
            busy_q       <= busy_d;
            desc_ready_q <= desc_ready_d;
        end
    end

    assign desc_ready  = desc_ready_q;
    assign Switch      = switch_q;
    assign Reg_4       = regs_q[31:0];
    assign Reg_5       = regs_q[63:32];
    assign Reg_6       = regs_q[95:64];
    assign Reg_7       = regs_q[127:96];
    assign Reg_8       = regs_q[159:128];
    assign Reg_9       = regs_q[191:160];
    assign Control_3_3 = ctrl33_q;
    assign Control_RE  = ctrlre_q;
    assign busy        = busy_q;
    assign layer_cnt   = layer_cnt_q;
    assign irq_done    = irq_done_q;
    assign irq_err     = irq_err_q;

    // Structural invariants of the registered outputs.
    ready_only_in_idle: assert property (@(posedge clk) disable iff (rst)
        desc_ready_q |-> (state_q == StIdle));
    start_only_in_start: assert property (@(posedge clk) disable iff (rst)
        ((ctrl33_q != 4'd0) || (ctrlre_q != 8'd0)) |-> (state_q == StStart));
    one_engine_started: assert property (@(posedge clk) disable iff (rst)
        $onehot0({ctrl33_q != 4'd0, ctrlre_q[3:0] != 4'd0, ctrlre_q[7:4] != 4'd0}));

endmodule

// File: tb/tb_tjpu_layer_sequencer.sv
// Directed bench for tjpu_layer_sequencer with hand-computed expectations.
// Watchdog is shortened to TIMEOUT_W=4 so the timeout fires after 15 RUN/DRAIN cycles.
module tb_tjpu_layer_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         run;
    logic         desc_valid;
    logic         desc_ready;
    logic [1:0]   desc_op;
    logic [191:0] desc_regs;
    logic [31:0]  Switch;
    logic [31:0]  Reg_4, Reg_5, Reg_6, Reg_7, Reg_8, Reg_9;
    logic [3:0]   Control_3_3;
    logic [7:0]   Control_RE;
    logic [3:0]   State_3_3;
    logic [7:0]   State_RE;
    logic         M_Last;
    logic         busy;
    logic [7:0]   layer_cnt;
    logic         irq_done;
    logic         irq_err;

    int nvec = 0;
    int nerr = 0;

    tjpu_layer_sequencer #(
        .CTRL_START(4'b0001),
        .TIMEOUT_W (4),
        .LAYER_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .desc_valid (desc_valid),
        .desc_ready (desc_ready),
        .desc_op    (desc_op),
        .desc_regs  (desc_regs),
        .Switch     (Switch),
        .Reg_4      (Reg_4),
        .Reg_5      (Reg_5),
        .Reg_6      (Reg_6),
        .Reg_7      (Reg_7),
        .Reg_8      (Reg_8),
        .Reg_9      (Reg_9),
        .Control_3_3(Control_3_3),
        .Control_RE (Control_RE),
        .State_3_3  (State_3_3),
        .State_RE   (State_RE),
        .M_Last     (M_Last),
        .busy       (busy),
        .layer_cnt  (layer_cnt),
        .irq_done   (irq_done),
        .irq_err    (irq_err)
    );

    always #5 clk = ~clk;

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; desc_valid = 1'b0; desc_op = 2'd0; desc_regs = '0;
        State_3_3 = 4'd0; State_RE = 8'd0; M_Last = 1'b0;
        tick();
        tick();
        nvec++;
        if ({Switch, Reg_4, Reg_5, Reg_6, Reg_7, Reg_8, Reg_9} !== 224'd0) begin
            nerr++; $display("FAIL reset_words: got %h, want 0",
                             {Switch, Reg_4, Reg_5, Reg_6, Reg_7, Reg_8, Reg_9});
        end
        nvec++;
        if ({Control_3_3, Control_RE} !== 12'h000) begin
            nerr++; $display("FAIL reset_ctrl: got %h, want 000", {Control_3_3, Control_RE});
        end
        nvec++;
        if ({desc_ready, busy, irq_done, irq_err} !== 4'b0000) begin
            nerr++; $display("FAIL reset_flags: got %b, want 0000",
                             {desc_ready, busy, irq_done, irq_err});
        end
        nvec++;
        if (layer_cnt !== 8'd0) begin
            nerr++; $display("FAIL reset_cnt: got %h, want 00", layer_cnt);
        end
        rst = 1'b0;
        tick();
        nvec++;
        if (desc_ready !== 1'b0) begin
            nerr++; $display("FAIL ready_without_run: got %b, want 0", desc_ready);
        end
    endtask

    task automatic test_conv_layer();
        run = 1'b1;
        tick();
        nvec++;
        if (desc_ready !== 1'b1) begin
            nerr++; $display("FAIL conv_ready: got %b, want 1", desc_ready);
        end
        desc_valid = 1'b1; desc_op = 2'd0;
        desc_regs = {32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
        tick();                               // accept edge -> CONFIG (T+1)
        desc_valid = 1'b0;
        nvec++;
        if (Switch !== 32'h0000_00E0) begin
            nerr++; $display("FAIL conv_switch: got %h, want 000000e0", Switch);
        end
        nvec++;
        if ({Reg_9, Reg_8, Reg_7, Reg_6, Reg_5, Reg_4} !==
            {32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11}) begin
            nerr++; $display("FAIL conv_regs: got %h/%h, want 66/11", Reg_9, Reg_4);
        end
        nvec++;
        if ({Control_3_3, Control_RE, busy, desc_ready} !== 14'b0000_00000000_1_0) begin
            nerr++; $display("FAIL conv_config: got %b, want 00000000000010",
                             {Control_3_3, Control_RE, busy, desc_ready});
        end
        tick();                               // START (T+2)
        nvec++;
        if ({Control_3_3, Control_RE} !== 12'h100) begin
            nerr++; $display("FAIL conv_start: got %h, want 100", {Control_3_3, Control_RE});
        end
        State_3_3 = 4'h3;
        tick();                               // RUN 1
        nvec++;
        if (Control_3_3 !== 4'd0) begin
            nerr++; $display("FAIL conv_start_len: got %h, want 0", Control_3_3);
        end
        tick();                               // RUN 2
        M_Last = 1'b1;
        tick();                               // DRAIN 1
        M_Last = 1'b0;
        nvec++;
        if ({busy, layer_cnt} !== {1'b1, 8'd0}) begin
            nerr++; $display("FAIL conv_drain: got %h, want 100", {busy, layer_cnt});
        end
        tick();                               // DRAIN 2, engine still busy
        nvec++;
        if ({busy, desc_ready} !== 2'b10) begin
            nerr++; $display("FAIL conv_drain_wait: got %b, want 10", {busy, desc_ready});
        end
        State_3_3 = 4'd0;
        tick();                               // IDLE
        nvec++;
        if ({layer_cnt, desc_ready, busy} !== {8'd1, 1'b1, 1'b0}) begin
            nerr++; $display("FAIL conv_done: got %h, want 006", {layer_cnt, desc_ready, busy});
        end
        nvec++;
        if (Switch !== 32'h0000_00E0) begin
            nerr++; $display("FAIL conv_switch_hold: got %h, want 000000e0", Switch);
        end
    endtask

    task automatic test_end_descriptor(input logic [31:0] exp_switch,
                                       input logic [31:0] exp_reg4,
                                       input logic [7:0]  cnt_before);
        M_Last = 1'b1;                        // stray beat in IDLE
        tick();
        M_Last = 1'b0;
        nvec++;
        if ({busy, Control_3_3, Control_RE, layer_cnt} !== {1'b0, 12'h000, cnt_before}) begin
            nerr++; $display("FAIL stray_mlast: got %h, want %h",
                             {busy, Control_3_3, Control_RE, layer_cnt},
                             {1'b0, 12'h000, cnt_before});
        end
        tick();
        nvec++;
        if ({busy, desc_ready} !== 2'b01) begin
            nerr++; $display("FAIL stray_idle: got %b, want 01", {busy, desc_ready});
        end
        desc_valid = 1'b1; desc_op = 2'd3; desc_regs = {192{1'b1}};
        tick();
        desc_valid = 1'b0;
        nvec++;
        if ({irq_done, busy, layer_cnt} !== {1'b1, 1'b0, 8'd0}) begin
            nerr++; $display("FAIL end_irq: got %h, want 200", {irq_done, busy, layer_cnt});
        end
        nvec++;
        if ({Switch, Reg_4} !== {exp_switch, exp_reg4}) begin
            nerr++; $display("FAIL end_hold: got %h, want %h", {Switch, Reg_4},
                             {exp_switch, exp_reg4});
        end
        tick();
        nvec++;
        if ({irq_done, desc_ready} !== 2'b01) begin
            nerr++; $display("FAIL end_pulse: got %b, want 01", {irq_done, desc_ready});
        end
    endtask

    task automatic test_back_to_back();
        desc_valid = 1'b1; desc_op = 2'd1;
        desc_regs = {32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1};
        tick();                               // CONFIG
        desc_valid = 1'b0;
        nvec++;
        if ({Switch, Reg_4, Control_RE} !== {32'h0000_0073, 32'hA1, 8'h00}) begin
            nerr++; $display("FAIL reshape_config: got %h, want 00000073000000a100",
                             {Switch, Reg_4, Control_RE});
        end
        tick();                               // START
        nvec++;
        if ({Control_3_3, Control_RE} !== 12'h001) begin
            nerr++; $display("FAIL reshape_start: got %h, want 001", {Control_3_3, Control_RE});
        end
        State_RE = 8'h04;
        tick();                               // RUN 1
        nvec++;
        if (Control_RE !== 8'h00) begin
            nerr++; $display("FAIL reshape_start_len: got %h, want 00", Control_RE);
        end
        M_Last = 1'b1;
        tick();                               // DRAIN
        M_Last = 1'b0;
        State_RE = 8'h00;
        tick();                               // IDLE, turnaround cycle 1
        nvec++;
        if ({layer_cnt, desc_ready} !== {8'd1, 1'b1}) begin
            nerr++; $display("FAIL reshape_done: got %h, want 003", {layer_cnt, desc_ready});
        end
        desc_valid = 1'b1; desc_op = 2'd2;
        desc_regs = {32'hB6, 32'hB5, 32'hB4, 32'hB3, 32'hB2, 32'hB1};
        tick();                               // CONFIG, turnaround cycle 2
        desc_valid = 1'b0;
        nvec++;
        if ({Reg_9, Switch, Control_RE} !== {32'hB6, 32'h0000_0073, 8'h00}) begin
            nerr++; $display("FAIL concat_config: got %h, want 000000b60000007300",
                             {Reg_9, Switch, Control_RE});
        end
        tick();                               // START, turnaround cycle 3
        nvec++;
        if ({Control_3_3, Control_RE} !== 12'h010) begin
            nerr++; $display("FAIL concat_start: got %h, want 010", {Control_3_3, Control_RE});
        end
        tick();                               // RUN 1: last beat with engine already idle
        M_Last = 1'b1;
        tick();                               // must still visit DRAIN
        M_Last = 1'b0;
        nvec++;
        if ({busy, layer_cnt} !== {1'b1, 8'd1}) begin
            nerr++; $display("FAIL concat_drain: got %h, want 101", {busy, layer_cnt});
        end
        tick();                               // IDLE
        nvec++;
        if ({busy, layer_cnt} !== {1'b0, 8'd2}) begin
            nerr++; $display("FAIL concat_done: got %h, want 002", {busy, layer_cnt});
        end
    endtask

    task automatic test_run_drop();
        desc_valid = 1'b1; desc_op = 2'd0;
        desc_regs = {32'hC6, 32'hC5, 32'hC4, 32'hC3, 32'hC2, 32'hC1};
        tick();                               // CONFIG
        desc_valid = 1'b0;
        tick();                               // START
        State_3_3 = 4'h1;
        tick();                               // RUN 1
        run = 1'b0;
        desc_valid = 1'b1; desc_op = 2'd1;    // offered but must not be taken
        M_Last = 1'b1;
        tick();                               // DRAIN
        M_Last = 1'b0;
        nvec++;
        if (busy !== 1'b1) begin
            nerr++; $display("FAIL drop_drain: got %b, want 1", busy);
        end
        State_3_3 = 4'h0;
        tick();                               // IDLE
        nvec++;
        if ({layer_cnt, busy, desc_ready} !== {8'd1, 1'b0, 1'b0}) begin
            nerr++; $display("FAIL drop_done: got %h, want 004", {layer_cnt, busy, desc_ready});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++;
            if ({busy, desc_ready, Switch} !== {2'b00, 32'h0000_00E0}) begin
                nerr++; $display("FAIL drop_no_accept: got %h, want 0000000e0",
                                 {busy, desc_ready, Switch});
            end
        end
        desc_valid = 1'b0;
        run = 1'b1;
        tick();
        nvec++;
        if (desc_ready !== 1'b1) begin
            nerr++; $display("FAIL drop_resume: got %b, want 1", desc_ready);
        end
    endtask

    task automatic test_rst_in_drain();
        desc_valid = 1'b1; desc_op = 2'd1;
        desc_regs = {32'hD6, 32'hD5, 32'hD4, 32'hD3, 32'hD2, 32'hD1};
        tick();                               // CONFIG
        desc_valid = 1'b0;
        tick();                               // START
        State_RE = 8'h05;
        tick();                               // RUN 1
        M_Last = 1'b1;
        tick();                               // DRAIN
        M_Last = 1'b0;
        nvec++;
        if ({busy, Switch} !== {1'b1, 32'h0000_0073}) begin
            nerr++; $display("FAIL rst_pre: got %h, want 100000073", {busy, Switch});
        end
        rst = 1'b1;
        tick();
        nvec++;
        if ({Switch, Reg_4, Reg_9} !== 96'd0) begin
            nerr++; $display("FAIL rst_words: got %h, want 0", {Switch, Reg_4, Reg_9});
        end
        nvec++;
        if ({busy, desc_ready, irq_done, irq_err, layer_cnt, Control_3_3, Control_RE} !==
            24'd0) begin
            nerr++; $display("FAIL rst_flags: got %h, want 0",
                             {busy, desc_ready, irq_done, irq_err, layer_cnt,
                              Control_3_3, Control_RE});
        end
        rst = 1'b0;
        State_RE = 8'h00;
        tick();
        nvec++;
        if ({busy, desc_ready} !== 2'b01) begin
            nerr++; $display("FAIL rst_recover: got %b, want 01", {busy, desc_ready});
        end
    endtask

    task automatic test_watchdog();
        desc_valid = 1'b1; desc_op = 2'd0;
        desc_regs = {32'hE6, 32'hE5, 32'hE4, 32'hE3, 32'hE2, 32'hE1};
        tick();                               // CONFIG
        desc_valid = 1'b0;
        tick();                               // START
        State_3_3 = 4'h2;
        for (int k = 1; k <= 15; k++) begin
            tick();                           // RUN cycle k
            nvec++;
            if ({irq_err, busy} !== 2'b01) begin
                nerr++; $display("FAIL wd_early cycle %0d: got %b, want 01", k, {irq_err, busy});
            end
        end
        tick();                               // edge after the 15th RUN cycle
        nvec++;
        if ({irq_err, desc_ready, busy, Control_3_3} !== {3'b101, 4'h0}) begin
            nerr++; $display("FAIL wd_fire: got %b, want 1010000",
                             {irq_err, desc_ready, busy, Control_3_3});
        end
        desc_valid = 1'b1; State_3_3 = 4'h0;
        for (int i = 0; i < 4; i++) begin
            M_Last = (i == 1);
            tick();
            nvec++;
            if ({irq_err, desc_ready, busy, layer_cnt} !== {3'b101, 8'd0}) begin
                nerr++; $display("FAIL wd_sticky: got %h, want 500",
                                 {irq_err, desc_ready, busy, layer_cnt});
            end
        end
        M_Last = 1'b0;
        desc_valid = 1'b0;
        rst = 1'b1;
        tick();
        nvec++;
        if ({irq_err, busy} !== 2'b00) begin
            nerr++; $display("FAIL wd_rst: got %b, want 00", {irq_err, busy});
        end
        rst = 1'b0;
        tick();
        nvec++;
        if ({desc_ready, irq_err} !== 2'b10) begin
            nerr++; $display("FAIL wd_recover: got %b, want 10", {desc_ready, irq_err});
        end
    endtask

    initial begin
        test_reset();
        test_conv_layer();
        test_end_descriptor(32'h0000_00E0, 32'h11, 8'd1);
        test_back_to_back();
        test_end_descriptor(32'h0000_0073, 32'hB1, 8'd2);
        test_run_drop();
        test_rst_in_drain();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/tjpu_layer_sequencer.md
# tjpu_layer_sequencer

Layer-level scheduler that sits in front of the TJPU compute top. It pops one layer descriptor at a time from a descriptor stream, programs the switch routing and parameter words (Reg_4..Reg_9), and issues a one-cycle start code to the Conv 3x3 engine or to the reshape/concat engine. It then waits for that layer's output stream to finish and the engine to return idle before fetching the next descriptor, with a watchdog timeout and completion/error interrupts toward the PS.

## Interface
- CTRL_START, 4'b0001: start code driven on the selected Control field for one cycle
- TIMEOUT_W, 24: watchdog counter width; timeout fires at 2^TIMEOUT_W−1 cycles in RUN/DRAIN
- LAYER_W, 8: layer counter width
- Reset polarity and synchronicity are fixed: one clock `clk`; `rst` is synchronous, active-high.
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- run  in  1  level enable; descriptors are accepted only while high
- desc_valid  in  1  descriptor available
- desc_ready  out  1  descriptor accepted when valid&&ready
- desc_op  in  2  0=conv3x3, 1=reshape, 2=concat, 3=end-of-network
- desc_regs  in  192  {Reg_9,Reg_8,Reg_7,Reg_6,Reg_5,Reg_4}, Reg_4 in LSBs
- Switch  out  32  {24'b0, suppress[3:0], 2'b0, dest[1:0]}
- Reg_4..Reg_9  out  32 each  layer parameter words, held for the whole layer
- Control_3_3  out  4  conv 3x3 start code
- Control_RE  out  8  [3:0] reshape start, [7:4] concat start
- State_3_3  in  4  conv engine state; 0 = idle
- State_RE  in  8  reshape/concat state; 0 = idle
- M_Last  in  1  output stream last-beat pulse (Tlast)
- busy  out  1  high in any state other than IDLE
- layer_cnt  out  LAYER_W  layers completed since the last end descriptor or reset
- irq_done  out  1  one-cycle pulse on end-of-network
- irq_err  out  1  sticky watchdog error flag; cleared only by rst

## Operation
- FSM states: IDLE, CONFIG, START, RUN, DRAIN, ERR.
- **IDLE**
  - desc_ready = run && !irq_err.
  - On accept with op 0–2: latch desc_regs into Reg_4..Reg_9, latch op, set Switch, go to CONFIG.
  - On accept with op 3: pulse irq_done, clear layer_cnt, stay in IDLE.
- **Switch encoding**
  - op 0: dest=0, suppress=4'b1110.
  - op 1 or 2: dest=3, suppress=4'b0111.
- **CONFIG**: one settle cycle with Reg/Switch stable and all Controls zero; go to START.
- **START**: for exactly one cycle, drive CTRL_START on Control_3_3 (op 0), Control_RE[3:0] (op 1), or Control_RE[7:4] (op 2). All other Control bits stay 0. Go to RUN.
- **RUN**: wait for M_Last=1, then go to DRAIN.
- **DRAIN**: wait for the selected engine's state to be 0 (State_3_3 for op 0, State_RE otherwise). Then increment layer_cnt (wraps at 2^LAYER_W) and go to IDLE.
- **Watchdog**
  - Counter clears on entering RUN and counts every cycle in RUN and DRAIN.
  - Reaching all-ones: set irq_err, force all Controls to 0, go to ERR.
- **ERR**: terminal until rst; desc_ready=0.
- **run deasserted mid-layer**: the current layer completes; no new descriptor is accepted.
- **M_Last in IDLE/CONFIG/START**: ignored. Stray beats never advance the FSM.
- **M_Last and engine idle in the same RUN cycle**: still passes through DRAIN, so the DRAIN check succeeds on the next cycle. Minimum 2 cycles from M_Last to IDLE.

## Timing
- **Reset values**: all outputs 0, state IDLE. Switch=0, Reg_4..Reg_9=0, Controls=0, layer_cnt=0, irq flags=0, desc_ready=0.
- **rst mid-layer**: immediate return to IDLE with all outputs at reset values. The engines are reset by the same rst.
- **Accept to start**: descriptor accept at cycle T; CONFIG at T+1; start code visible at T+2 for one cycle only.
- **Registered outputs**: all outputs are registered. desc_ready is a registered function of next state, so it is never high outside IDLE.
- **Layer to layer**: minimum turnaround from DRAIN exit to next start code is 3 cycles (IDLE accept, CONFIG, START).
- **Holding**: Reg and Switch outputs change only on descriptor accept.
- **irq_done**: high for one cycle, the cycle after the end-descriptor accept.

## Test plan
- **Conv layer**: reset, run=1, op=0 with regs 0x11..0x66. Expect Switch=0x0000_00E0 at T+1, Control_3_3=4'b0001 only at T+2. Pulse M_Last, then drop State_3_3 to 0; expect layer_cnt=1 and desc_ready=1.
- **Reshape then concat back to back**:
  - Reshape layer: Switch=0x0000_0073 and Control_RE=8'h01.
  - Concat layer: Control_RE=8'h10.
  - layer_cnt=2 after both; 3-cycle turnaround between layers.
- **End descriptor**: op=3 after 2 layers gives irq_done for one cycle and layer_cnt=0. Stray M_Last pulses in IDLE leave state unchanged.
- **Watchdog**: TIMEOUT_W=4, start conv, never pulse M_Last. Expect irq_err=1 at the 15th RUN cycle, desc_ready held 0, recovery only after rst.
- **Mid-layer stop and reset**:
  - run dropped during RUN: the layer finishes and no further accept occurs.
  - rst asserted during DRAIN: all outputs return to 0 the following cycle.
